// File: rtl/bin_to_bcd_seq.sv
// Sequential signed-binary to BCD converter (shift-and-add-3, one bit per clock).
// Latency: start edge to done edge is BIT_SIZE+1 clocks; outputs are registered.
// Backpressure: none; start is ignored while busy, and a start in the done cycle is accepted.
module bin_to_bcd_seq #(
    parameter int BIT_SIZE = 20,
    parameter int DIGITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIT_SIZE-1:0]   number,
    input  logic                  is_signed,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic [2:0]            msd_index,
    output logic                  overflow
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = 6;
    localparam logic [BIT_SIZE-1:0] ONE   = BIT_SIZE'(1);
    localparam logic [AW-1:0]       NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_SIZE-1:0] bin_q, bin_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [AW-1:0]       bcd_q, bcd_d;
    logic                negative_q, negative_d;
    logic [2:0]          msd_q, msd_d;
    logic                overflow_q, overflow_d;

    logic                neg_in;
    logic [BIT_SIZE-1:0] abs_in;
    logic [AW-1:0]       adj;
    logic [AW-1:0]       fin_bcd;
    logic [2:0]          msd_calc;

    // Sign and magnitude of the incoming operand; the most negative value maps to 2^(BIT_SIZE-1).
    always_comb begin
        neg_in = is_signed & number[BIT_SIZE-1];
        abs_in = neg_in ? ((~number) + ONE) : number;
    end

    // Add-3 correction on every nibble >= 5; each nibble wraps within 4 bits, no carry between digits.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final digit pattern (saturated on overflow) and index of its highest non-zero digit.
    always_comb begin
        fin_bcd  = ovf_q ? NINES : acc_q;
        msd_calc = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (fin_bcd[4*i +: 4] != 4'd0) begin
                msd_calc = 3'(i);
            end
        end
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        negative_d = negative_q;
        msd_d      = msd_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_d   = neg_in;
                    bin_d   = abs_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A bit leaving the top digit means the value needs more digits than we have.
                acc_d = {adj[AW-2:0], bin_q[BIT_SIZE-1]};
                bin_d = {bin_q[BIT_SIZE-2:0], 1'b0};
                ovf_d = ovf_q | adj[AW-1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIT_SIZE - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d      = fin_bcd;
                negative_d = neg_q;
                msd_d      = msd_calc;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and clears the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            negative_q <= 1'b0;
            msd_q      <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            negative_q <= negative_d;
            msd_q      <= msd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign negative  = negative_q;
    assign msd_index = msd_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes model results, a monitor checks on done.
// Expected done time is start edge + BIT_SIZE + 1.
// Random operands are mixed with directed extremes, protocol abuse and mid-conversion reset.
module tb_bin_to_bcd_seq;

    localparam int BS = 20;
    localparam int DG = 6;

    typedef struct {
        logic [4*DG-1:0] bcd;
        logic            neg;
        logic [2:0]      msd;
        logic            ovf;
        int              cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BS-1:0]     number;
    logic              is_signed;
    logic              busy;
    logic              done;
    logic [4*DG-1:0]   bcd;
    logic              negative;
    logic [2:0]        msd_index;
    logic              overflow;

    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    exp_t              sb_q[$];
    logic [4*DG-1:0]   prev_bcd = '0;

    bin_to_bcd_seq #(.BIT_SIZE(BS), .DIGITS(DG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .negative  (negative),
        .msd_index (msd_index),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain decimal arithmetic on the magnitude.
    function automatic exp_t model(input logic [BS-1:0] n, input logic s, input int c);
        exp_t   e;
        longint v;
        longint lim;
        longint t;
        longint d;
        e.neg = s & n[BS-1];
        v     = e.neg ? ((longint'(1) << BS) - longint'(n)) : longint'(n);
        lim   = 1;
        for (int i = 0; i < DG; i++) lim = lim * 10;
        e.ovf = (v >= lim);
        e.bcd = '0;
        t     = v;
        for (int i = 0; i < DG; i++) begin
            d = e.ovf ? 64'd9 : (t % 10);
            t = t / 10;
            e.bcd[4*i +: 4] = d[3:0];
        end
        e.msd = 3'd0;
        for (int i = 0; i < DG; i++) begin
            if (e.bcd[4*i +: 4] != 4'd0) e.msd = 3'(i);
        end
        e.cyc = c + BS + 2;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("negative", 32'(negative), 32'(e.neg));
                chk("msd_index", 32'(msd_index), 32'(e.msd));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, want done", n);
        end
    endtask

    // Called at a negedge; leaves at the negedge where done is visible, so chained calls are back-to-back.
    task automatic convert(input logic [BS-1:0] n, input logic s);
        exp_t e;
        number    = n;
        is_signed = s;
        start     = 1'b1;
        e = model(n, s, cyc);
        sb_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        number    = BS'($urandom);
        is_signed = 1'($urandom);
        repeat (4) @(negedge clk);
        chk("hold_bcd", 32'(bcd), 32'(prev_bcd));
        chk("busy_mid", 32'(busy), 32'd1);
        prev_bcd = e.bcd;
        wait_done();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bcd"}, 32'(bcd), 32'd0);
        chk({tag, "_negative"}, 32'(negative), 32'd0);
        chk({tag, "_msd"}, 32'(msd_index), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [BS-1:0] r;
        rst       = 1'b1;
        start     = 1'b0;
        number    = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed values and extremes.
        convert(BS'(12345), 1'b0);
        repeat (3) @(negedge clk);
        convert(20'hFFC75, 1'b1);
        convert(20'h80000, 1'b1);
        convert(20'hFFFFF, 1'b0);
        convert(20'h00000, 1'b0);
        convert(20'h00000, 1'b1);
        convert(20'h7FFFF, 1'b1);
        convert(20'hFFFFF, 1'b1);
        convert(BS'(999999), 1'b0);
        convert(BS'(1000000), 1'b0);

        // Start while busy is ignored; inputs changing mid-flight have no effect.
        repeat (2) @(negedge clk);
        number    = BS'(42);
        is_signed = 1'b0;
        start     = 1'b1;
        e = model(BS'(42), 1'b0, cyc);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        number = BS'(77);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev_bcd = e.bcd;
        wait_done();
        convert(BS'(77), 1'b0);

        // Reset in the middle of a conversion: abort, clear, no done.
        @(negedge clk);
        number    = BS'(654321);
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("midreset");
        prev_bcd = '0;
        repeat (30) @(negedge clk);

        // Reset and start together: reset wins.
        number = BS'(5);
        rst    = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        repeat (25) @(negedge clk);
        convert(BS'(31337), 1'b0);

        // Random operands, mostly back-to-back.
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 4))
                0:       r = BS'($urandom_range(0, 99));
                1:       r = {1'b1, BS'($urandom) >> 1};
                2:       r = BS'($urandom_range(999000, 1048575));
                default: r = BS'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            convert(r, 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
